// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated four-way phase scheduler: round-robin among latched requests,
// with min/extension/max green followed by yellow and all-red clearance.
module traffic_phase_arbiter #(
  parameter int CLK_FREQ    = 100,
  parameter int ALL_RED_T   = CLK_FREQ / 2,
  parameter int YELLOW_T    = CLK_FREQ / 2,
  parameter int MIN_GREEN_T = CLK_FREQ,
  parameter int MAX_GREEN_T = CLK_FREQ * 3,
  parameter int EXT_T       = CLK_FREQ / 2,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [2:0] North,
  output logic [2:0] East,
  output logic [2:0] South,
  output logic [2:0] West,
  output logic [3:0] grant,
  output logic [3:0] pending,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_GREEN  = 2'd2;
  localparam logic [1:0] S_YELLOW = 2'd3;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [CNT_W-1:0] L_ALL_RED_LAST = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] L_YELLOW_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_MIN_LAST     = CNT_W'(MIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] L_MAX_LAST     = CNT_W'(MAX_GREEN_T - 1);
  localparam logic [CNT_W-1:0] L_EXT          = CNT_W'(EXT_T);

  logic [1:0]       r_state;
  logic [1:0]       r_cur;
  logic [1:0]       r_rr;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_greenCnt;
  logic [CNT_W-1:0] r_gapCnt;
  logic [3:0]       r_pending;
  logic [3:0]       r_grant;
  logic [3:0][2:0]  r_lamps;

  logic [1:0] w_sel;
  logic       w_selValid;
  logic [1:0] w_nextState;
  logic [1:0] w_nextCur;
  logic       w_enterGreen;
  logic [3:0] w_others;
  logic       w_greenExit;
  logic [3:0] w_greenMask;

  // Highest priority is the approach at the rr pointer, so it is assigned last.
  always_comb begin
    w_sel      = r_rr;
    w_selValid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (r_pending[r_rr + 2'(k)]) begin
        w_sel      = r_rr + 2'(k);
        w_selValid = 1'b1;
      end
    end
  end

  assign w_others    = r_pending & ~r_grant;
  assign w_greenExit = (w_others != 4'b0000) &&
                       (((r_greenCnt >= L_MIN_LAST) && (r_gapCnt >= L_EXT)) ||
                        (r_greenCnt == L_MAX_LAST));

  always_comb begin
    w_nextState  = r_state;
    w_nextCur    = r_cur;
    w_enterGreen = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_selValid) begin
          w_nextState  = S_GREEN;
          w_nextCur    = w_sel;
          w_enterGreen = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_timer == L_ALL_RED_LAST) begin
          if (w_selValid) begin
            w_nextState  = S_GREEN;
            w_nextCur    = w_sel;
            w_enterGreen = 1'b1;
          end else begin
            w_nextState = S_IDLE;
          end
        end
      end
      S_GREEN: begin
        if (w_greenExit) w_nextState = S_YELLOW;
      end
      default: begin
        if (r_timer == L_YELLOW_LAST) w_nextState = S_CLEAR;
      end
    endcase
  end

  // The served approach never latches its own request while it is green.
  always_comb begin
    w_greenMask = 4'b0000;
    if (r_state == S_GREEN) w_greenMask = w_greenMask | (4'b0001 << r_cur);
    if (w_enterGreen)       w_greenMask = w_greenMask | (4'b0001 << w_sel);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_cur      <= 2'd0;
      r_rr       <= 2'd0;
      r_timer    <= '0;
      r_greenCnt <= '0;
      r_gapCnt   <= '0;
      r_pending  <= 4'b0000;
      r_grant    <= 4'b0000;
      r_lamps    <= {4{LAMP_R}};
    end else begin
      r_state   <= w_nextState;
      r_cur     <= w_nextCur;
      r_pending <= (r_pending | req) & ~w_greenMask;

      if ((w_nextState != r_state) || (w_nextState == S_IDLE) || (w_nextState == S_GREEN))
        r_timer <= '0;
      else
        r_timer <= r_timer + CNT_W'(1);

      if (w_enterGreen) begin
        r_greenCnt <= '0;
        r_gapCnt   <= '0;
      end else if (r_state == S_GREEN) begin
        if (r_greenCnt < L_MAX_LAST) r_greenCnt <= r_greenCnt + CNT_W'(1);
        if (req[r_cur])              r_gapCnt   <= '0;
        else if (r_gapCnt < L_EXT)   r_gapCnt   <= r_gapCnt + CNT_W'(1);
      end else begin
        r_greenCnt <= '0;
        r_gapCnt   <= '0;
      end

      if ((r_state == S_YELLOW) && (w_nextState == S_CLEAR))
        r_rr <= r_cur + 2'd1;

      if ((w_nextState == S_GREEN) || (w_nextState == S_YELLOW))
        r_grant <= 4'b0001 << w_nextCur;
      else
        r_grant <= 4'b0000;

      for (int i = 0; i < 4; i++) begin
        if ((w_nextCur == 2'(i)) && (w_nextState == S_GREEN))
          r_lamps[i] <= LAMP_G;
        else if ((w_nextCur == 2'(i)) && (w_nextState == S_YELLOW))
          r_lamps[i] <= LAMP_Y;
        else
          r_lamps[i] <= LAMP_R;
      end
    end
  end

  assign North   = r_lamps[0];
  assign East    = r_lamps[1];
  assign South   = r_lamps[2];
  assign West    = r_lamps[3];
  assign grant   = r_grant;
  assign pending = r_pending;
  assign state   = r_state;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: directed scenarios with closed-form timing,
// then random demand compared each cycle against a phase-level reference model.
module tb_traffic_phase_arbiter;

  localparam int ALL_RED_T   = 50;
  localparam int YELLOW_T    = 50;
  localparam int MIN_GREEN_T = 100;
  localparam int MAX_GREEN_T = 300;
  localparam int EXT_T       = 50;
  localparam logic [11:0] ALL_RED = {4{3'b100}};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [2:0] north, east, south, west;
  logic [3:0] grant, pending;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int         mPhase, mElapsed, mGreen, mGap, mCur, mRr;
  logic [3:0] mPend;

  always #5 clk = ~clk;

  traffic_phase_arbiter #(.CLK_FREQ(100)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .North(north), .East(east), .South(south), .West(west),
    .grant(grant), .pending(pending), .state(state)
  );

  function automatic logic [11:0] lampsFor(input int phase, input int cur);
    logic [11:0] v;
    v = ALL_RED;
    if (phase == 2) v[11 - 3*cur -: 3] = 3'b001;
    if (phase == 3) v[11 - 3*cur -: 3] = 3'b010;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    step();
    req = 4'b0000;
  endtask

  // Requests are held high during reset to show they are ignored.
  task automatic doReset(input int n);
    reset_n = 1'b0;
    req = 4'b1111;
    repeat (n) step();
    reset_n = 1'b1;
    req = 4'b0000;
    cyc = 0;
  endtask

  task automatic test_reset();
    doReset(2);
    checks++; if ({north, east, south, west} !== ALL_RED) begin errors++;
      $display("[TB] FAIL reset_lamps: got %b expected %b", {north, east, south, west}, ALL_RED); end
    checks++; if (state !== 2'd1) begin errors++;
      $display("[TB] FAIL reset_state: got %0d expected 1", state); end
    checks++; if (grant !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (pending !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_pending: got %b expected 0000", pending); end
  endtask

  task automatic test_idle();
    int n;
    int bad;
    doReset(2);
    n = 1;
    while (state == 2'd1 && n < 200) begin
      step();
      if (state == 2'd1) n++;
    end
    checks++; if (n != ALL_RED_T) begin errors++;
      $display("[TB] FAIL idle_clear_len: got %0d expected %0d", n, ALL_RED_T); end
    bad = 0;
    repeat (100) begin
      step();
      if (state !== 2'd0 || grant !== 4'b0000 || {north, east, south, west} !== ALL_RED) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("[TB] FAIL idle_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_resting_green();
    int bad;
    doReset(2);
    runTo(10);
    pulse(4'b0010);
    checks++; if (pending !== 4'b0010) begin errors++;
      $display("[TB] FAIL rest_pending: got %b expected 0010", pending); end
    runTo(49);
    checks++; if (state !== 2'd1) begin errors++;
      $display("[TB] FAIL rest_clear49: got %0d expected 1", state); end
    runTo(50);
    checks++; if ({north, east, south, west} !== lampsFor(2, 1)) begin errors++;
      $display("[TB] FAIL rest_entry_lamps: got %b expected %b", {north, east, south, west}, lampsFor(2, 1)); end
    checks++; if (grant !== 4'b0010 || pending !== 4'b0000) begin errors++;
      $display("[TB] FAIL rest_entry_gp: got %b/%b expected 0010/0000", grant, pending); end
    bad = 0;
    repeat (300) begin
      step();
      if ({north, east, south, west} !== lampsFor(2, 1) || pending !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("[TB] FAIL rest_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_max_green();
    int gEnd;
    doReset(2);
    req = 4'b0101;
    step();
    req = 4'b0001;
    gEnd = 50 + MAX_GREEN_T;
    runTo(50);
    checks++; if ({north, east, south, west} !== lampsFor(2, 0)) begin errors++;
      $display("[TB] FAIL max_start: got %b expected %b", {north, east, south, west}, lampsFor(2, 0)); end
    runTo(gEnd - 1);
    checks++; if ({north, east, south, west} !== lampsFor(2, 0)) begin errors++;
      $display("[TB] FAIL max_last_green: got %b expected %b", {north, east, south, west}, lampsFor(2, 0)); end
    runTo(gEnd);
    checks++; if ({north, east, south, west} !== lampsFor(3, 0) || grant !== 4'b0001) begin errors++;
      $display("[TB] FAIL max_yellow: got %b/%b expected %b/0001", {north, east, south, west}, grant, lampsFor(3, 0)); end
    runTo(gEnd + YELLOW_T - 1);
    checks++; if ({north, east, south, west} !== lampsFor(3, 0)) begin errors++;
      $display("[TB] FAIL max_yellow_end: got %b expected %b", {north, east, south, west}, lampsFor(3, 0)); end
    runTo(gEnd + YELLOW_T);
    checks++; if ({north, east, south, west} !== ALL_RED || state !== 2'd1) begin errors++;
      $display("[TB] FAIL max_clear: got %b/%0d expected %b/1", {north, east, south, west}, state, ALL_RED); end
    runTo(gEnd + YELLOW_T + ALL_RED_T - 1);
    checks++; if ({north, east, south, west} !== ALL_RED) begin errors++;
      $display("[TB] FAIL max_clear_end: got %b expected %b", {north, east, south, west}, ALL_RED); end
    runTo(gEnd + YELLOW_T + ALL_RED_T);
    checks++; if ({north, east, south, west} !== lampsFor(2, 2)) begin errors++;
      $display("[TB] FAIL max_south: got %b expected %b", {north, east, south, west}, lampsFor(2, 2)); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    int start;
    int ap;
    doReset(2);
    pulse(4'b1111);
    for (int k = 0; k < 5; k++) begin
      start = 50 + k * (MIN_GREEN_T + YELLOW_T + ALL_RED_T);
      ap = k % 4;
      runTo(start);
      checks++; if ({north, east, south, west} !== lampsFor(2, ap) || grant !== 4'(1 << ap)) begin errors++;
        $display("[TB] FAIL rr_start%0d: got %b/%b expected %b/%b", k, {north, east, south, west}, grant, lampsFor(2, ap), 4'(1 << ap)); end
      runTo(start + MIN_GREEN_T - 1);
      checks++; if ({north, east, south, west} !== lampsFor(2, ap)) begin errors++;
        $display("[TB] FAIL rr_green_end%0d: got %b expected %b", k, {north, east, south, west}, lampsFor(2, ap)); end
      runTo(start + MIN_GREEN_T);
      checks++; if ({north, east, south, west} !== lampsFor(3, ap)) begin errors++;
        $display("[TB] FAIL rr_yellow%0d: got %b expected %b", k, {north, east, south, west}, lampsFor(3, ap)); end
      pulse(4'b1111);
    end
  endtask

  task automatic test_gap_extension();
    doReset(2);
    pulse(4'b1001);
    runTo(90);
    pulse(4'b0001);
    checks++; if (pending !== 4'b1000) begin errors++;
      $display("[TB] FAIL gap_no_latch: got %b expected 1000", pending); end
    runTo(130);
    pulse(4'b0001);
    runTo(170);
    pulse(4'b0001);
    runTo(50 + 120 + 1 + EXT_T);
    checks++; if ({north, east, south, west} !== lampsFor(2, 0)) begin errors++;
      $display("[TB] FAIL gap_still_green: got %b expected %b", {north, east, south, west}, lampsFor(2, 0)); end
    runTo(50 + 120 + 2 + EXT_T);
    checks++; if ({north, east, south, west} !== lampsFor(3, 0)) begin errors++;
      $display("[TB] FAIL gap_yellow: got %b expected %b", {north, east, south, west}, lampsFor(3, 0)); end
  endtask

  task automatic test_reset_mid_yellow();
    doReset(2);
    pulse(4'b0110);
    runTo(50 + MIN_GREEN_T);
    checks++; if ({north, east, south, west} !== lampsFor(3, 1)) begin errors++;
      $display("[TB] FAIL mid_pre_yellow: got %b expected %b", {north, east, south, west}, lampsFor(3, 1)); end
    runTo(160);
    reset_n = 1'b0;
    req = 4'b1111;
    step();
    reset_n = 1'b1;
    req = 4'b0000;
    cyc = 0;
    checks++; if ({north, east, south, west} !== ALL_RED || grant !== 4'b0000) begin errors++;
      $display("[TB] FAIL mid_abort: got %b/%b expected %b/0000", {north, east, south, west}, grant, ALL_RED); end
    checks++; if (pending !== 4'b0000 || state !== 2'd1) begin errors++;
      $display("[TB] FAIL mid_state: got %b/%0d expected 0000/1", pending, state); end
    pulse(4'b0110);
    runTo(50);
    checks++; if ({north, east, south, west} !== lampsFor(2, 1) || grant !== 4'b0010) begin errors++;
      $display("[TB] FAIL mid_east_first: got %b/%b expected %b/0010", {north, east, south, west}, grant, lampsFor(2, 1)); end
  endtask

  function automatic int pick(input logic [3:0] p, input int from);
    for (int off = 0; off < 4; off++)
      if (p[(from + off) % 4]) return (from + off) % 4;
    return -1;
  endfunction

  task automatic modelReset();
    mPhase = 1; mElapsed = 0; mGreen = 0; mGap = 0; mCur = 0; mRr = 0; mPend = 4'b0000;
  endtask

  // Phases: 0 idle, 1 all-red, 2 green, 3 yellow; mElapsed counts cycles in a timed phase.
  task automatic modelStep(input logic [3:0] r);
    int sel;
    logic [3:0] nextPend;
    logic [3:0] others;
    sel = pick(mPend, mRr);
    nextPend = mPend | r;
    if (mPhase == 2) nextPend[mCur] = 1'b0;
    case (mPhase)
      0: if (sel >= 0) begin mPhase = 2; mCur = sel; mGreen = 0; mGap = 0; nextPend[sel] = 1'b0; end
      1: begin
        if (mElapsed == ALL_RED_T - 1) begin
          mElapsed = 0;
          if (sel >= 0) begin mPhase = 2; mCur = sel; mGreen = 0; mGap = 0; nextPend[sel] = 1'b0; end
          else mPhase = 0;
        end else mElapsed++;
      end
      2: begin
        others = mPend & ~(4'b0001 << mCur);
        if (others != 0 && ((mGreen >= MIN_GREEN_T - 1 && mGap >= EXT_T) || mGreen == MAX_GREEN_T - 1)) begin
          mPhase = 3; mElapsed = 0;
        end else begin
          mGreen = (mGreen + 1 > MAX_GREEN_T - 1) ? MAX_GREEN_T - 1 : mGreen + 1;
          mGap = r[mCur] ? 0 : ((mGap + 1 > EXT_T) ? EXT_T : mGap + 1);
        end
      end
      default: begin
        if (mElapsed == YELLOW_T - 1) begin mPhase = 1; mElapsed = 0; mRr = (mCur + 1) % 4; end
        else mElapsed++;
      end
    endcase
    mPend = nextPend;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rstLow;
    logic [3:0] expGrant;
    int holdBit;
    int holdLeft;
    int lit;
    holdBit = 0;
    holdLeft = 0;
    doReset(2);
    modelReset();
    repeat (4000) begin
      r = 4'b0000;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 99) < 2) r[b] = 1'b1;
      if (holdLeft > 0) begin
        r[holdBit] = 1'b1;
        holdLeft--;
      end else if ($urandom_range(0, 299) == 0) begin
        holdBit = int'($urandom_range(0, 3));
        holdLeft = int'($urandom_range(20, 400));
      end
      rstLow = ($urandom_range(0, 1999) == 0);
      req = r;
      reset_n = ~rstLow;
      step();
      if (rstLow) modelReset();
      else modelStep(r);
      expGrant = (mPhase >= 2) ? 4'(1 << mCur) : 4'b0000;
      checks++; if (state !== 2'(mPhase)) begin errors++;
        $display("[TB] FAIL rnd_state@%0d: got %0d expected %0d", cyc, state, mPhase); end
      checks++; if (grant !== expGrant) begin errors++;
        $display("[TB] FAIL rnd_grant@%0d: got %b expected %b", cyc, grant, expGrant); end
      checks++; if (pending !== mPend) begin errors++;
        $display("[TB] FAIL rnd_pending@%0d: got %b expected %b", cyc, pending, mPend); end
      checks++; if ({north, east, south, west} !== lampsFor(mPhase, mCur)) begin errors++;
        $display("[TB] FAIL rnd_lamps@%0d: got %b expected %b", cyc, {north, east, south, west}, lampsFor(mPhase, mCur)); end
      lit = int'(north != 3'b100) + int'(east != 3'b100) + int'(south != 3'b100) + int'(west != 3'b100);
      checks++; if (lit > 1) begin errors++;
        $display("[TB] FAIL rnd_conflict@%0d: got %0d non-red expected at most 1", cyc, lit); end
    end
    req = 4'b0000;
    reset_n = 1'b1;
  endtask

  initial begin
    $display("[TB] starting traffic_phase_arbiter bench");
    test_reset();
    test_idle();
    test_resting_green();
    test_max_green();
    test_round_robin();
    test_gap_extension();
    test_reset_mid_yellow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
